// File: rtl/aurora_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aurora_tx_pkg
//  Description : Shared constants and types for the Aurora 64b/66b TX block
//                scheduler: sync headers, block-type bytes, fixed control
//                blocks, selector and state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package aurora_tx_pkg;

    // 64b/66b sync headers
    localparam logic [1:0]  HDR_DATA = 2'b01;
    localparam logic [1:0]  HDR_CTRL = 2'b10;

    // Block-type field of control blocks
    localparam logic [7:0]  BTF_IDLE = 8'h78;
    localparam logic [7:0]  BTF_SVC  = 8'hD2;

    // Clock-compensation marker byte carried in the first payload byte after the BTF
    localparam logic [7:0]  CC_MARK  = 8'h80;

    // Fixed control blocks
    localparam logic [65:0] IDLE_BLK = {HDR_CTRL, BTF_IDLE, 56'h0};
    localparam logic [65:0] CC_BLK   = {HDR_CTRL, BTF_IDLE, CC_MARK, 48'h0};

    // Block source chosen for the current slot
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_CC   = 2'd1,
        SEL_SVC  = 2'd2,
        SEL_DATA = 2'd3
    } sel_t;

    // Scheduler state: INIT sends the start-up idles, RUN carries traffic
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } st_t;

endpackage : aurora_tx_pkg
`default_nettype wire

// File: rtl/aurora_tx_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : aurora_tx_block_scheduler
//  Description : Picks one 66-bit Aurora block per gearbox request from the
//                init-idle, clock-compensation, service, hit-data and filler
//                idle sources, and pops the matching FWFT FIFO on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module aurora_tx_block_scheduler
    import aurora_tx_pkg::*;
#(
    parameter int INIT_IDLES = 16,
    parameter int CC_PERIOD  = 1024,
    parameter int RATIO_W    = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Enable,
    input  logic               BlockNext,
    input  logic               DataValid,
    input  logic [63:0]        Data64,
    output logic               DataRead,
    input  logic               SvcValid,
    input  logic [55:0]        Svc56,
    output logic               SvcRead,
    input  logic [RATIO_W-1:0] SvcRatio,
    output logic [65:0]        Block66,
    output logic               LinkReady,
    output logic               CcSent
);

    localparam int c_SLOT_W = (INIT_IDLES > 1) ? $clog2(INIT_IDLES) : 1;
    localparam int c_CC_W   = (CC_PERIOD  > 1) ? $clog2(CC_PERIOD)  : 1;

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(INIT_IDLES - 1);
    localparam logic [c_CC_W-1:0]   c_CC_LAST   = c_CC_W'(CC_PERIOD - 1);
    localparam logic [RATIO_W-1:0]  c_RUN_MAX   = '1;

    st_t                 r_state;
    logic [c_SLOT_W-1:0] r_slot_cnt;
    logic [c_CC_W-1:0]   r_cc_cnt;
    logic [RATIO_W-1:0]  r_run_cnt;
    logic [65:0]         r_block;
    logic                r_cc_sent;

    sel_t                w_sel;
    logic [65:0]         w_blk;

    // Slot selector: CC outranks everything, service wins once data has had
    // its SvcRatio-long run (or no data is waiting), then data, then filler.
    always_comb begin
        w_sel = SEL_IDLE;
        w_blk = IDLE_BLK;
        if (r_state == RUN) begin
            if (r_cc_cnt == c_CC_LAST) begin
                w_sel = SEL_CC;
            end else if (Enable && SvcValid && (!DataValid || (r_run_cnt >= SvcRatio))) begin
                w_sel = SEL_SVC;
            end else if (Enable && DataValid) begin
                w_sel = SEL_DATA;
            end
        end
        case (w_sel)
            SEL_CC:   w_blk = CC_BLK;
            SEL_SVC:  w_blk = {HDR_CTRL, BTF_SVC, Svc56};
            SEL_DATA: w_blk = {HDR_DATA, Data64};
            default:  w_blk = IDLE_BLK;
        endcase
    end

    // Pops happen on the same edge that loads the word into Block66
    assign DataRead  = BlockNext && (w_sel == SEL_DATA) && !Rst;
    assign SvcRead   = BlockNext && (w_sel == SEL_SVC)  && !Rst;

    assign Block66   = r_block;
    assign LinkReady = (r_state == RUN);
    assign CcSent    = r_cc_sent;

    // Register bank: everything advances only on gearbox strobes; reset wins
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= INIT;
            r_slot_cnt <= '0;
            r_cc_cnt   <= '0;
            r_run_cnt  <= '0;
            r_block    <= IDLE_BLK;
            r_cc_sent  <= 1'b0;
        end else if (BlockNext) begin
            r_block   <= w_blk;
            r_cc_sent <= (w_sel == SEL_CC);

            // Start-up idle count, then hand over to RUN for the following slot
            if (r_state == INIT) begin
                r_cc_cnt   <= '0;
                r_slot_cnt <= r_slot_cnt + c_SLOT_W'(1);
                if (r_slot_cnt == c_SLOT_LAST) begin
                    r_state <= RUN;
                end
            end else begin
                if (w_sel == SEL_CC) begin
                    r_cc_cnt <= '0;
                end else begin
                    r_cc_cnt <= r_cc_cnt + c_CC_W'(1);
                end
            end

            // Length of the current data run while service is waiting
            if ((w_sel == SEL_SVC) || !SvcValid) begin
                r_run_cnt <= '0;
            end else if ((w_sel == SEL_DATA) && (r_run_cnt != c_RUN_MAX)) begin
                r_run_cnt <= r_run_cnt + RATIO_W'(1);
            end
        end else begin
            r_cc_sent <= 1'b0;
        end
    end

endmodule : aurora_tx_block_scheduler
`default_nettype wire

// File: tb/tb_aurora_tx_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aurora_tx_block_scheduler
//  Description : Directed self-checking bench for the Aurora TX block
//                scheduler (INIT_IDLES=4, CC_PERIOD=8, RATIO_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_block_scheduler;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Enable = 1'b0;
    logic        BlockNext = 1'b0;
    logic        DataValid = 1'b0;
    logic [63:0] Data64 = '0;
    logic        DataRead;
    logic        SvcValid = 1'b0;
    logic [55:0] Svc56 = '0;
    logic        SvcRead;
    logic [3:0]  SvcRatio = '0;
    logic [65:0] Block66;
    logic        LinkReady;
    logic        CcSent;

    aurora_tx_block_scheduler #(
        .INIT_IDLES (4),
        .CC_PERIOD  (8),
        .RATIO_W    (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Enable    (Enable),
        .BlockNext (BlockNext),
        .DataValid (DataValid),
        .Data64    (Data64),
        .DataRead  (DataRead),
        .SvcValid  (SvcValid),
        .Svc56     (Svc56),
        .SvcRead   (SvcRead),
        .SvcRatio  (SvcRatio),
        .Block66   (Block66),
        .LinkReady (LinkReady),
        .CcSent    (CcSent)
    );

    always #5 Clk = ~Clk;

    localparam logic [65:0] c_IDLE = {2'b10, 8'h78, 56'h0};
    localparam logic [65:0] c_CC   = {2'b10, 8'h78, 8'h80, 48'h0};

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_spop   = 0;
    int          n_dpop   = 0;
    int          word_id  = 0;
    logic [65:0] got_blk;
    logic        got_cc, got_lr, got_dr, got_sr;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One strobe starting at a falling edge; pops sampled before the rising
    // edge, registered outputs sampled at the next falling edge.
    task automatic strobe(input int gap);
        BlockNext = 1'b1;
        #1;
        got_dr = DataRead;
        got_sr = SvcRead;
        @(negedge Clk);
        BlockNext = 1'b0;
        got_blk = Block66;
        got_cc  = CcSent;
        got_lr  = LinkReady;
        repeat (gap) @(negedge Clk);
    endtask

    // One slot with fresh FIFO head words and a hand-derived expected kind
    task automatic slot(input string tag, input byte kind, input int gap);
        logic [65:0] exp;
        word_id++;
        Data64 = 64'hDA7A_0000_0000_0000 + 64'(word_id);
        Svc56  = 56'h5E_0000_0000_0000 + 56'(word_id);
        case (kind)
            8'h43:   exp = c_CC;                          // 'C'
            8'h44:   exp = {2'b01, Data64};               // 'D'
            8'h53:   exp = {2'b10, 8'hD2, Svc56};         // 'S'
            default: exp = c_IDLE;                        // 'I'
        endcase
        strobe(gap);
        n_dpop += int'(got_dr);
        n_spop += int'(got_sr);
        check({tag, " blk"},  got_blk,      exp);
        check({tag, " dpop"}, 66'(got_dr),  66'(kind == 8'h44));
        check({tag, " spop"}, 66'(got_sr),  66'(kind == 8'h53));
        check({tag, " cc"},   66'(got_cc),  66'(kind == 8'h43));
    endtask

    task automatic run_pattern(input string tag, input string pat, input int gap);
        for (int i = 0; i < pat.len(); i++) begin
            slot($sformatf("%s[%0d]", tag, i), pat[i], gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0;

        // Reset with data waiting; a strobe during reset must not pop
        DataValid = 1'b1;
        Enable    = 1'b1;
        repeat (2) @(negedge Clk);
        BlockNext = 1'b1;
        #1;
        check("rst dpop", 66'(DataRead), 66'd0);
        check("rst spop", 66'(SvcRead),  66'd0);
        @(negedge Clk);
        BlockNext = 1'b0;
        check("rst blk",  Block66,          c_IDLE);
        check("rst lr",   66'(LinkReady),   66'd0);
        check("rst cc",   66'(CcSent),      66'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Test 1: four init idles, LinkReady after the 4th, then data
        run_pattern("t1 init", "III", 2);
        check("t1 lr3", 66'(got_lr), 66'd0);
        run_pattern("t1 init4", "I", 2);
        check("t1 lr4", 66'(got_lr), 66'd1);
        run_pattern("t1 first", "D", 2);

        // Test 2: continuous data, CC on every 8th RUN slot
        run_pattern("t2", "DDDDDDC", 2);
        check("t2 ccpulse", 66'(CcSent), 66'd0);
        run_pattern("t2b", "DDDDDDDC", 2);

        // Test 3: SvcRatio=2, both sources always valid
        SvcRatio = 4'd2;
        SvcValid = 1'b1;
        s0 = n_spop;
        run_pattern("t3", "DDSDDSDCDS", 2);
        check("t3 svc pops", 66'(n_spop - s0), 66'd3);

        // Test 4: service strict priority
        SvcRatio = 4'd0;
        run_pattern("t4", "SSSSS", 2);
        check("t4 hdr", 66'(got_blk[65:56]), 66'h2D2);
        run_pattern("t4b", "CSS", 2);

        // Test 5: disabled sends only idle/CC, resumes on the next strobe
        Enable = 1'b0;
        s0 = n_spop + n_dpop;
        run_pattern("t5", "IIIIICII", 2);
        check("t5 pops", 66'(n_spop + n_dpop - s0), 66'd0);
        Enable = 1'b1;
        run_pattern("t5 resume", "S", 2);

        // Back-to-back strobes, data only
        SvcValid = 1'b0;
        run_pattern("b2b", "DDDDC", 0);
        run_pattern("b2b end", "D", 2);

        // Test 6: reset coincident with a strobe mid-run
        Rst       = 1'b1;
        BlockNext = 1'b1;
        #1;
        check("t6 dpop", 66'(DataRead), 66'd0);
        @(negedge Clk);
        Rst       = 1'b0;
        BlockNext = 1'b0;
        check("t6 blk", Block66,        c_IDLE);
        check("t6 lr",  66'(LinkReady), 66'd0);
        @(negedge Clk);
        run_pattern("t6 init", "IIII", 2);
        check("t6 lr4", 66'(got_lr), 66'd1);
        run_pattern("t6 data", "D", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aurora_tx_block_scheduler
`default_nettype wire
